// File: rtl/fp_align_add.sv
// fp_align_add: binary32 unpack, magnitude order, iterative align and significand add/sub
// Ports: clk/rst_n (sync active-low); in_valid/in_ready, op_a, op_b, op_sub operand handshake;
// out_valid/out_ready result handshake; sign, carry, exponent, mantissa[24:0], special result fields.
module fp_align_add #(
  parameter int MAX_SHIFT = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign,
  output logic        carry,
  output logic [7:0]  exponent,
  output logic [24:0] mantissa,
  output logic        special
);
  typedef enum logic [1:0] {IDLE, ALIGN, ADD, HOLD} state_t;
  state_t state;
  logic sign_l, sign_s, spec;
  logic [7:0] exp_l, diff, ea, eb, d;
  logic [23:0] m_l, m_s, ma, mb;
  logic a_big, sb, zero;
  logic [24:0] sum;
  assign ea = op_a[30:23];
  assign eb = op_b[30:23];
  // zero-exponent operands are flushed to zero (no denormals)
  assign ma = (ea != 8'd0) ? {1'b1, op_a[22:0]} : 24'd0;
  assign mb = (eb != 8'd0) ? {1'b1, op_b[22:0]} : 24'd0;
  assign sb = op_b[31] ^ op_sub;
  assign a_big = op_a[30:0] >= op_b[30:0];
  assign d = a_big ? ea - eb : eb - ea;
  // L >= S in magnitude, so the difference never goes negative
  assign sum = (sign_l == sign_s) ? {1'b0, m_l} + {1'b0, m_s} : {1'b0, m_l} - {1'b0, m_s};
  assign zero = (sign_l != sign_s) && (sum == 25'd0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sign      <= 1'b0;
      carry     <= 1'b0;
      exponent  <= 8'd0;
      mantissa  <= 25'd0;
      special   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state    <= ALIGN;
          in_ready <= 1'b0;
          sign_l   <= a_big ? op_a[31] : sb;
          sign_s   <= a_big ? sb : op_a[31];
          exp_l    <= a_big ? ea : eb;
          m_l      <= a_big ? ma : mb;
          m_s      <= (d > 8'(MAX_SHIFT)) ? 24'd0 : (a_big ? mb : ma);
          diff     <= (d > 8'(MAX_SHIFT)) ? 8'd0 : d;
          spec     <= (ea == 8'hff) || (eb == 8'hff);
        end
        ALIGN: if (diff != 8'd0) begin
          m_s  <= m_s >> 1;
          diff <= diff - 8'd1;
        end else state <= ADD;
        ADD: begin
          state     <= HOLD;
          out_valid <= 1'b1;
          special   <= spec;
          sign      <= sign_l & (spec | ~zero);
          carry     <= ~spec & sum[24];
          exponent  <= spec ? 8'hff : (zero ? 8'd0 : exp_l);
          mantissa  <= spec ? {1'b0, m_l} : sum;
        end
        HOLD: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_align_add.sv
// tb_fp_align_add: scoreboard bench for fp_align_add covering plan vectors, handshake, reset and random ops
module tb_fp_align_add;
  logic clk = 1'b0, rst_n, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic sign, carry, special;
  logic [31:0] op_a, op_b;
  logic [7:0] exponent;
  logic [24:0] mantissa;
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [35:0] res; int lat;} exp_t;
  exp_t q[$];
  fp_align_add dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .sign(sign), .carry(carry), .exponent(exponent),
    .mantissa(mantissa), .special(special)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [7:0] ea, eb, el, es, d;
    logic [23:0] ma, mb, ml, ms;
    logic sa, sbb, sl, ss;
    logic [24:0] r;
    exp_t e;
    ea = a[30:23]; eb = b[30:23];
    ma = (ea == 0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (eb == 0) ? 24'd0 : {1'b1, b[22:0]};
    sa = a[31]; sbb = b[31] ^ sub;
    if (a[30:0] >= b[30:0]) {el, ml, sl, es, ms, ss} = {ea, ma, sa, eb, mb, sbb};
    else {el, ml, sl, es, ms, ss} = {eb, mb, sbb, ea, ma, sa};
    d = el - es;
    if (d > 24) begin ms = 0; d = 0; end
    ms = ms >> d;
    r = (sl == ss) ? {1'b0, ml} + {1'b0, ms} : {1'b0, ml} - {1'b0, ms};
    if (ea == 8'hff || eb == 8'hff) e.res = {1'b1, sl, 1'b0, 8'hff, 1'b0, ml};
    else if (sl != ss && r == 0) e.res = 36'd0;
    else e.res = {1'b0, sl, r[24], el, r};
    e.lat = int'(d) + 2;
    return e;
  endfunction
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic sub, input exp_t e, input int hold);
    exp_t w;
    int n;
    q.push_back(e);
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1 n++; end
    w = q.pop_front();
    chk("latency", n, w.lat);
    chk("result", {special, sign, carry, exponent, mantissa}, w.res);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_result", {special, sign, carry, exponent, mantissa}, w.res);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
  endtask
  function automatic exp_t k(input logic [35:0] res, input int lat);
    exp_t e;
    e.res = res; e.lat = lat;
    return e;
  endfunction
  initial begin
    logic [31:0] a, b;
    logic s;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = 0; op_b = 0; op_sub = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_fields", {special, sign, carry, exponent, mantissa}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(32'h3F800000, 32'h3F800000, 1'b0, k({3'b001, 8'h7F, 25'h1000000}, 2), 0);
    run(32'h3FC00000, 32'h3E800000, 1'b0, k({3'b000, 8'h7F, 25'h0E00000}, 4), 0);
    run(32'h3F800000, 32'hC0000000, 1'b0, k({3'b010, 8'h80, 25'h0400000}, 3), 0);
    run(32'h40490FDB, 32'h40490FDB, 1'b1, k(36'd0, 2), 0);
    run(32'h4B800000, 32'h3F800000, 1'b0, k({3'b000, 8'h97, 25'h0800000}, 26), 0);
    run(32'h4E800000, 32'h3F800000, 1'b0, k({3'b000, 8'h9D, 25'h0800000}, 2), 0);
    run(32'h7F800000, 32'h3F800000, 1'b0, k({3'b100, 8'hFF, 25'h0800000}, 2), 0);
    run(32'h3F800000, 32'h40000000, 1'b1, k({3'b010, 8'h80, 25'h0400000}, 3), 5);
    op_a = 32'h49800000; op_b = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_fields", {special, sign, carry, exponent, mantissa}, 0);
    repeat (25) @(posedge clk);
    #1 chk("midrst_idle", out_valid, 0);
    run(32'h3FC00000, 32'h3E800000, 1'b0, k({3'b000, 8'h7F, 25'h0E00000}, 4), 1);
    for (int i = 0; i < 30; i++) begin
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
      b = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
      if (i % 10 == 3) b[30:23] = 8'h00;
      if (i % 10 == 7) a[30:23] = 8'hff;
      if (i % 10 == 5) b = a;
      s = 1'($urandom_range(0, 1));
      run(a, b, s, model(a, b, s), $urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_align_add.md
Name: fp_align_add

Overview:
- Front half of the single-precision floating-point adder.
- Accepts two IEEE-754 binary32 operands and an add/subtract select, then unpacks them and orders them by magnitude.
- Aligns the smaller significand with an iterative right shift, one bit per cycle, then adds or subtracts the significands.
- Produces sign, carry, common exponent and a 25-bit raw significand. These are the exact inputs of the downstream normalise/final-output stage.

Parameters:
- MAX_SHIFT, 24, largest exponent difference that is shifted iteratively; larger differences zero the smaller significand in the capture cycle.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands (IDLE only).
- op_a  input  32  operand A, binary32.
- op_b  input  32  operand B, binary32.
- op_sub  input  1  1 = A - B (sign of B inverted at capture).
- out_valid  output  1  result fields valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- sign  output  1  result sign.
- carry  output  1  significand sum overflowed (equals mantissa[24]).
- exponent  output  8  exponent of larger operand.
- mantissa  output  25  raw significand result, hidden bit at [23].
- special  output  1  an operand had exponent 0xFF; other fields carry the larger operand, unchanged.

Behaviour:
- Reset (rst_n low at an edge, any state): state IDLE; in_ready=1; out_valid=0; sign/carry/special=0; exponent=0; mantissa=0. Any in-flight operation is discarded.
- States: IDLE, ALIGN, ADD, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: unpack both operands. Hidden bit = (exp!=0); exp==0 operands are treated as zero (significand 0, no denormal support).
  - B's effective sign = op_b[31]^op_sub.
  - Larger = greater {exp,frac}; on a tie, A is the larger.
  - Swap so L is the larger and S the smaller.
  - diff = expL-expS. If diff>MAX_SHIFT, load S significand=0 and diff=0.
  - Next state ALIGN.
- ALIGN:
  - While diff!=0: S significand >>= 1 (bits shifted out are discarded, no guard/sticky bits); diff -= 1.
  - When diff==0: next state ADD.
  - No early exit when the significand reaches zero.
- ADD (one cycle, results registered):
  - Same effective signs: mantissa = {1'b0,mL}+{1'b0,mS}; carry = mantissa[24].
  - Different signs: mantissa = mL-mS (never negative); carry=0.
  - sign = sign of L; exponent = expL.
  - Zero result from subtraction: sign=0, exponent=0, mantissa=0.
  - If either operand exponent==0xFF: special=1, exponent=0xFF, mantissa={1'b0,fracL with hidden bit}, sign=sign of L, carry=0.
  - Next state HOLD; out_valid=1.
- HOLD:
  - Outputs stable while out_valid and !out_ready.
  - On out_ready: out_valid=0, next state IDLE. The next operands can be accepted one cycle later; no back-to-back overlap.
- Latency: the accept edge is edge 0. out_valid rises after edge diff_eff+2, where diff_eff is 0..MAX_SHIFT. Throughput: one operation per diff_eff+4 cycles minimum.
- in_valid is ignored outside IDLE. op_a and op_b are sampled only at the accept edge.

Test Plan:
- 1.0+1.0: op_a=op_b=0x3F800000, op_sub=0 -> out_valid 2 cycles after accept; carry=1, mantissa=0x1000000, exponent=0x7F, sign=0.
- 1.5+0.25: op_a=0x3FC00000, op_b=0x3E800000 -> diff 2, out_valid after 4 cycles; mantissa=0x0E00000, carry=0, exponent=0x7F, sign=0.
- Swap and mixed signs:
  - Stimulus: op_a=0x3F800000, op_b=0xC0000000, op_sub=0.
  - Response: L=B; mantissa=0x0400000, exponent=0x80, sign=1, carry=0.
  - The downstream stage then yields -1.0.
- Exact cancellation: op_a=op_b=0x40490FDB, op_sub=1 -> mantissa=0, exponent=0, sign=0, carry=0.
- Shift limits:
  - op_a=0x4B800000, op_b=0x3F800000 (diff 24) -> out_valid after 26 cycles; mantissa=0x0800000.
  - op_a=0x4E800000, op_b=0x3F800000 (diff 30) -> out_valid after 2 cycles; same mantissa.
- Handshake/reset:
  - out_ready held low 5 cycles -> fields and out_valid stable, in_ready=0.
  - rst_n low for one edge during ALIGN of a diff-20 op -> next cycle IDLE, out_valid=0, in_ready=1, all outputs 0.
  - A fresh op then completes correctly.
